// File: rtl/param_read_pkg.sv
// Shared types and constants for the parameter read scheduler.
// Build option: define PARAM_READ_SCHED_TAG_EN to add the out_tag stream port.
package param_read_pkg;

  localparam int PARAM_W = 4;
  localparam int WIN_W   = 3;
  localparam int ADDR_W  = PARAM_W + WIN_W;

  // Requester identifiers; also used as the in-flight read tag and rr pointer.
  localparam logic REQ_SWEEP = 1'b0;
  localparam logic REQ_HOST  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SWEEP,
    FLUSH,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/sched_fifo2.sv
// Two-entry synchronous FIFO used to buffer sweep read data.
// The caller guarantees no push when full and no pop when empty.
module sched_fifo2 #(
  parameter int W = 16
) (
  input  logic         pll_clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] entry_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;

  // Storage, pointers and occupancy; push and pop together keep count unchanged
  always_ff @(posedge pll_clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_reg[0] <= '0;
      entry_reg[1] <= '0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count        <= 2'd0;
    end else begin
      if (push) begin
        entry_reg[wr_ptr_reg] <= din;
        wr_ptr_reg            <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

  assign dout = entry_reg[rd_ptr_reg];

endmodule

// File: rtl/param_read_sched.sv
// Scheduler for the single hybd_top parameter read port. Shares the port
// between a settle-then-sweep engine (streamed out through a 2-entry FIFO)
// and a host random-access port, with round-robin arbitration.
// Build option: PARAM_READ_SCHED_TAG_EN adds out_tag ({param,window} per word).
module param_read_sched
  import param_read_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_PARAM  = 16,
  parameter int NUM_WIN    = 6,
  parameter int SETTLE_CYC = 2000,
  parameter int CNT_W      = 16
) (
  input  logic              pll_clk,
  input  logic              reset_n,
  input  logic              test_done,
  input  logic              start,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef PARAM_READ_SCHED_TAG_EN
  output logic [ADDR_W-1:0] out_tag,
`endif
  output logic              busy,
  output logic              done
);

  localparam logic [PARAM_W-1:0] LAST_PARAM  = PARAM_W'(NUM_PARAM - 1);
  localparam logic [WIN_W-1:0]   LAST_WIN    = WIN_W'(NUM_WIN - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

`ifdef PARAM_READ_SCHED_TAG_EN
  localparam int FIFO_W = DATA_W + ADDR_W;
`else
  localparam int FIFO_W = DATA_W;
`endif

  sweep_state_t       state_reg, state_next;
  logic [CNT_W-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [PARAM_W-1:0] param_reg, param_next;
  logic [WIN_W-1:0]   win_reg, win_next;

  logic rd_vld_reg;        // a real read was issued last cycle
  logic rd_tag_reg;        // who owns that read
  logic host_pend_reg;     // host was granted last cycle
  logic host_bad_reg;      // ... with an out-of-range window
  logic rr_last_reg;       // last requester granted

  logic              sweep_inflight;
  logic              sweep_elig;
  logic              host_elig;
  logic              host_win_ok;
  logic              grant_host;
  logic              grant_sweep;
  logic [2:0]        occ;
  logic              fifo_push;
  logic              fifo_pop;
  logic [1:0]        fifo_count;
  logic [FIFO_W-1:0] fifo_din;
  logic [FIFO_W-1:0] fifo_dout;

  // A sweep slot is consumed from issue until the word leaves the FIFO;
  // a pop this cycle already frees its slot.
  assign sweep_inflight = rd_vld_reg && (rd_tag_reg == REQ_SWEEP);
  assign fifo_pop       = out_valid && out_ready;
  assign occ            = {1'b0, fifo_count} + {2'b00, sweep_inflight} - {2'b00, fifo_pop};
  assign sweep_elig     = (state_reg == SWEEP) && (occ < 3'd2);
  // Host is masked during reset so every output is quiet while reset_n is low.
  assign host_elig      = host_req && reset_n;
  assign host_win_ok    = host_addr[WIN_W-1:0] <= LAST_WIN;

  // Round robin: on a tie the requester not granted last wins
  assign grant_host  = host_elig && (!sweep_elig || (rr_last_reg == REQ_SWEEP));
  assign grant_sweep = sweep_elig && !grant_host;

  assign rd_req   = grant_sweep || (grant_host && host_win_ok);
  assign rd_addr  = grant_host  ? host_addr :
                    grant_sweep ? {param_reg, win_reg} : '0;
  assign host_gnt = grant_host;

  // Host response lines up with rd_data, one cycle after the grant
  assign host_rvalid = host_pend_reg;
  assign host_err    = host_pend_reg && host_bad_reg;
  assign host_rdata  = (host_pend_reg && !host_bad_reg) ? rd_data : '0;

  assign fifo_push = sweep_inflight;

`ifdef PARAM_READ_SCHED_TAG_EN
  logic [ADDR_W-1:0] rd_addr_q_reg;

  // Remember the issued address so the returning word can carry it
  always_ff @(posedge pll_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q_reg <= '0;
    end else begin
      rd_addr_q_reg <= rd_addr;
    end
  end

  assign fifo_din = {rd_addr_q_reg, rd_data};
  assign out_tag  = fifo_dout[FIFO_W-1:DATA_W];
`else
  assign fifo_din = rd_data;
`endif

  assign out_data  = fifo_dout[DATA_W-1:0];
  assign out_valid = (fifo_count != 2'd0);

  sched_fifo2 #(
    .W (FIFO_W)
  ) u_fifo (
    .pll_clk (pll_clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .count   (fifo_count)
  );

  // Sweep FSM state and sweep position registers
  always_ff @(posedge pll_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= '0;
      param_reg      <= '0;
      win_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      param_reg      <= param_next;
      win_reg        <= win_next;
    end
  end

  // Issue bookkeeping: routing tag of the read in flight and rr pointer
  always_ff @(posedge pll_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_reg    <= 1'b0;
      rd_tag_reg    <= REQ_SWEEP;
      host_pend_reg <= 1'b0;
      host_bad_reg  <= 1'b0;
      rr_last_reg   <= REQ_HOST;
    end else begin
      rd_vld_reg    <= rd_req;
      rd_tag_reg    <= grant_host ? REQ_HOST : REQ_SWEEP;
      host_pend_reg <= grant_host;
      host_bad_reg  <= grant_host && !host_win_ok;
      if (grant_host) begin
        rr_last_reg <= REQ_HOST;
      end else if (grant_sweep) begin
        rr_last_reg <= REQ_SWEEP;
      end
    end
  end

  // Next-state logic: settle wait, param-inner sweep walk, drain, done
  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    param_next      = param_reg;
    win_next        = win_reg;
    busy            = 1'b0;
    done            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next      = WAIT;
          settle_cnt_next = '0;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (test_done) begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_next = SWEEP;
            param_next = '0;
            win_next   = '0;
          end else begin
            settle_cnt_next = settle_cnt_reg + 1'b1;
          end
        end
      end
      SWEEP: begin
        busy = 1'b1;
        if (grant_sweep) begin
          if (param_reg == LAST_PARAM) begin
            param_next = '0;
            if (win_reg == LAST_WIN) begin
              state_next = FLUSH;
            end else begin
              win_next = win_reg + 1'b1;
            end
          end else begin
            param_next = param_reg + 1'b1;
          end
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (!sweep_inflight && (fifo_count == 2'd0 || (fifo_count == 2'd1 && fifo_pop))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next      = WAIT;
          settle_cnt_next = '0;
          param_next      = '0;
          win_next        = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_param_read_sched.sv
// Scoreboard bench for param_read_sched (SETTLE_CYC reduced to 20).
// Stimulus pushes expected sweep addresses/words and host responses into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_param_read_sched;

  logic        pll_clk = 1'b0;
  logic        reset_n;
  logic        test_done;
  logic        start;
  logic        rd_req;
  logic [6:0]  rd_addr;
  logic [15:0] rd_data;
  logic        host_req;
  logic [6:0]  host_addr;
  logic        host_gnt;
  logic        host_rvalid;
  logic [15:0] host_rdata;
  logic        host_err;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic        done;
`ifdef PARAM_READ_SCHED_TAG_EN
  logic [6:0]  out_tag;
`endif

  always #5 pll_clk = ~pll_clk;

  param_read_sched #(
    .DATA_W     (16),
    .NUM_PARAM  (16),
    .NUM_WIN    (6),
    .SETTLE_CYC (20),
    .CNT_W      (16)
  ) dut (
    .pll_clk     (pll_clk),
    .reset_n     (reset_n),
    .test_done   (test_done),
    .start       (start),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .host_req    (host_req),
    .host_addr   (host_addr),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .host_err    (host_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
`ifdef PARAM_READ_SCHED_TAG_EN
    .out_tag     (out_tag),
`endif
    .busy        (busy),
    .done        (done)
  );

  // Model of the hybd_top parameter memory contents
  function automatic logic [15:0] mem_val(input logic [6:0] a);
    return {a, ~a, 2'b10};
  endfunction

  // hybd_top read port: data valid the cycle after rd_req
  always @(posedge pll_clk) rd_data <= rd_req ? mem_val(rd_addr) : 16'hDEAD;

  int cyc = 0;
  always @(posedge pll_clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [6:0]  exp_sw_addr_q [$];
  logic [15:0] exp_out_q [$];
  logic [16:0] exp_host_q [$];
  logic [1:0]  gnt_log [4096];
  int          outstanding = 0;
  int          sw_issued   = 0;
  int          last_sw_cyc = 0;
  logic        gnt_prev    = 1'b0;

  // Monitor: compare everything the DUT presents this cycle
  initial begin
    logic [6:0]  ea;
    logic [15:0] ed;
    logic [16:0] eh;
    forever begin
      @(negedge pll_clk);
      if (reset_n) begin
        if (cyc < 4096) gnt_log[cyc] = host_gnt ? 2'd2 : (rd_req ? 2'd1 : 2'd0);
        if (host_gnt) begin
          if (host_addr[2:0] < 3'd6) begin
            check_eq("host_rd_req", rd_req, 1);
            if (rd_req) check_eq("host_rd_addr", rd_addr, host_addr);
          end else begin
            check_eq("host_err_no_rd_req", rd_req, 0);
          end
        end else if (rd_req) begin
          check_eq("sweep_rd_expected", exp_sw_addr_q.size() > 0, 1);
          if (exp_sw_addr_q.size() > 0) begin
            ea = exp_sw_addr_q.pop_front();
            check_eq("sweep_rd_addr", rd_addr, ea);
          end
          sw_issued++;
          outstanding++;
          last_sw_cyc = cyc;
        end
        if (host_rvalid || gnt_prev) check_eq("host_rvalid_timing", host_rvalid, gnt_prev);
        if (host_rvalid) begin
          check_eq("host_resp_expected", exp_host_q.size() > 0, 1);
          if (exp_host_q.size() > 0) begin
            eh = exp_host_q.pop_front();
            check_eq("host_err_rdata", {host_err, host_rdata}, eh);
            $display("host resp cyc=%0d err=%0b rdata=0x%04h", cyc, host_err, host_rdata);
          end
        end
        if (out_valid && out_ready) begin
          check_eq("stream_expected", exp_out_q.size() > 0, 1);
          if (exp_out_q.size() > 0) begin
            ed = exp_out_q.pop_front();
            check_eq("stream_data", out_data, ed);
            $display("stream word cyc=%0d data=0x%04h", cyc, out_data);
          end
          outstanding--;
        end
        gnt_prev = host_gnt;
      end else begin
        gnt_prev = 1'b0;
      end
    end
  end

  // Host requester: level request held until granted, then next address
  logic [6:0] h_list [12];
  int h_idx = 0;
  int h_cnt = 0;
  initial begin
    host_req  = 1'b0;
    host_addr = 7'h00;
    forever begin
      @(posedge pll_clk);
      #2;
      host_req = (h_idx < h_cnt);
      if (host_req) host_addr = h_list[h_idx];
      @(negedge pll_clk);
      if (reset_n && host_req && host_gnt) begin
        if (host_addr[2:0] >= 3'd6) exp_host_q.push_back({1'b1, 16'h0000});
        else                        exp_host_q.push_back({1'b0, mem_val(host_addr)});
        $display("host gnt cyc=%0d addr=0x%02h", cyc, host_addr);
        h_idx++;
      end
    end
  end

  task automatic push_sweep();
    logic [6:0] a;
    for (int i = 0; i < 96; i++) begin
      a = {4'(i % 16), 3'(i / 16)};
      exp_sw_addr_q.push_back(a);
      exp_out_q.push_back(mem_val(a));
    end
  endtask

  // Pulse start at k=0 and return the k of the first sweep issue
  task automatic start_sweep(input bit gap, input int host_at, output int first_k, output int c0);
    first_k = -1;
    c0 = 0;
    for (int k = 0; k < 200 && first_k < 0; k++) begin
      @(posedge pll_clk);
      #1;
      if (k == 0) c0 = cyc;
      start     = (k == 0);
      test_done = gap ? ((k >= 10 && k < 20) || k >= 25) : 1'b1;
      if (k == host_at) h_cnt = 12;
      @(negedge pll_clk);
      if (rd_req && !host_gnt) begin
        first_k = k;
        check_eq("busy_in_sweep", {busy, done}, 2'b10);
      end
    end
    start = 1'b0;
  endtask

  // Full sweep completes: last issue L, drain L+1/L+2, done from L+3
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 600) begin
      @(negedge pll_clk);
      n++;
    end
    check_eq("done_seen", done, 1);
    check_eq("done_latency", cyc - last_sw_cyc, 3);
    check_eq("sweep_addrs_left", exp_sw_addr_q.size(), 0);
    check_eq("stream_words_left", exp_out_q.size(), 0);
    check_eq("busy_after_done", busy, 0);
  endtask

  initial begin
    int fk, c0, base, n;
    bit found;
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fk, c0, base, n;
    bit found;
    reset_n   = 1'b0;
    test_done = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    h_list = '{7'h00, 7'h11, 7'h7D, 7'h45, 7'h0A, 7'h2E, 7'h63, 7'h1C, 7'h30, 7'h7A, 7'h55, 7'h0F};

    // Reset state
    repeat (3) @(negedge pll_clk);
    check_eq("reset_outputs",
             {rd_req, host_gnt, host_rvalid, host_err, out_valid, busy, done, rd_addr, host_rdata, out_data},
             64'd0);
    #2 reset_n = 1'b1;

    // Settle wait with a 5-cycle test_done gap, then full sweep at out_ready=1
    push_sweep();
    start_sweep(1'b1, -1, fk, c0);
    check_eq("settle_first_issue_k", fk, 35);
    wait_done();

    // Back-pressure: stall the stream for 50 cycles mid-sweep
    push_sweep();
    start_sweep(1'b0, -1, fk, c0);
    check_eq("rearm_first_issue_k", fk, 21);
    base = sw_issued;
    n = 0;
    while (sw_issued < base + 10 && n < 200) begin
      @(negedge pll_clk);
      n++;
    end
    @(posedge pll_clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pll_clk);
      check_eq("stall_outstanding_le2", outstanding <= 2, 1);
    end
    check_eq("stall_fill", outstanding, 2);
    @(posedge pll_clk);
    #1 out_ready = 1'b1;
    wait_done();

    // Contention: host requests held from two cycles before SWEEP
    push_sweep();
    start_sweep(1'b0, 19, fk, c0);
    check_eq("contend_first_issue_k", fk, 21);
    wait_done();
    check_eq("host_wait_gnt0", gnt_log[c0 + 19], 2);
    check_eq("host_wait_gnt1", gnt_log[c0 + 20], 2);
    for (int j = 0; j < 20; j++) begin
      check_eq("rr_alternate", gnt_log[c0 + 21 + j], (j % 2 == 1) ? 2 : 1);
    end
    check_eq("host_all_granted", h_idx, 12);

    // Reset mid-sweep at address 0x23
    push_sweep();
    start_sweep(1'b0, -1, fk, c0);
    found = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      @(negedge pll_clk);
      n++;
      if (rd_req && !host_gnt && rd_addr == 7'h23) found = 1'b1;
    end
    check_eq("reached_0x23", found, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midreset_outputs",
             {rd_req, host_gnt, host_rvalid, host_err, out_valid, busy, done, rd_addr, host_rdata, out_data},
             64'd0);
    exp_sw_addr_q.delete();
    exp_out_q.delete();
    exp_host_q.delete();
    outstanding = 0;
    repeat (2) @(negedge pll_clk);
    #2 reset_n = 1'b1;
    @(negedge pll_clk);
    check_eq("post_reset_idle", {busy, done, out_valid, rd_req}, 4'b0000);

    // New start re-sweeps from 0x00
    push_sweep();
    start_sweep(1'b0, -1, fk, c0);
    check_eq("resweep_first_issue_k", fk, 21);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
